// File: rtl/accum_pkg.sv
// accum_pkg: shared types and defaults for the accumulator scheduler.
// Holds the FSM state encoding, default widths and a saturating-increment helper.
package accum_pkg;

  localparam int W_DEF       = 4;
  localparam int CNT_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Increment that sticks at maxv instead of wrapping.
  function automatic int unsigned sat_inc(
    input int unsigned v,
    input int unsigned maxv
  );
    return (v >= maxv) ? maxv : v + 1;
  endfunction

endpackage

// File: rtl/accum_rr_arb.sv
// accum_rr_arb: 2-way round-robin arbiter, combinational; pointer kept by caller.
// Ports: req[1:0] requests, ptr favoured requester, gnt granted index, any request present.
module accum_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt,
  output logic       any
);

  always_comb begin
    any = |req;
    gnt = req[ptr] ? ptr : ~ptr;
  end

endmodule

// File: rtl/accum_sched.sv
// accum_sched: shares one external W-bit accumulator between two operand streams.
// Ports: PHI/RST_N, REQ_* operand handshakes, ACC_* accumulator link, RES_* result handshake.
module accum_sched
  import accum_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic             PHI,
  input  logic             RST_N,
  input  logic [1:0]       REQ_VALID,
  input  logic [2*W-1:0]   REQ_DATA,
  input  logic [1:0]       REQ_LAST,
  output logic [1:0]       REQ_READY,
  output logic [W-1:0]     ACC_A,
  output logic             ACC_CIN,
  output logic             ACC_RST,
  input  logic [W-1:0]     ACC_SOUT,
  input  logic             ACC_COUT,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic             RES_ID,
  output logic [W-1:0]     RES_SUM,
  output logic             RES_OVF,
  output logic [CNT_W-1:0] RES_CNT,
  output logic             RES_ERR
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [TMR_W-1:0] TMR_END = TMR_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             g_q, g_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;

  logic             arb_gnt;
  logic             arb_any;
  logic             g_valid;
  logic             g_last;
  logic [W-1:0]     g_data;

  accum_rr_arb u_arb (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .any (arb_any)
  );

  always_comb begin
    g_valid = REQ_VALID[g_q];
    g_last  = REQ_LAST[g_q];
    g_data  = REQ_DATA[g_q*W +: W];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      S_IDLE: begin
        if (arb_any) begin
          g_d     = arb_gnt;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          cnt_d   = '0;
          tmr_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (g_valid) begin
          // Accumulator adds on this same edge; carry is
          // combinational so it is sampled here.
          ovf_d = ovf_q | ACC_COUT;
          cnt_d = CNT_W'(sat_inc(32'(cnt_q), CNT_MAX));
          tmr_d = '0;
          if (g_last) state_d = S_DONE;
        end else if (tmr_q == TMR_END) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_DONE: begin
        if (RES_READY) begin
          ptr_d   = ~g_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge PHI) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      g_q     <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    REQ_READY = 2'b00;
    ACC_A     = '0;
    ACC_CIN   = 1'b0;
    ACC_RST   = 1'b0;
    RES_VALID = 1'b0;
    RES_ID    = 1'b0;
    RES_SUM   = '0;
    RES_OVF   = 1'b0;
    RES_CNT   = '0;
    RES_ERR   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ACC_RST = 1'b1;
      end
      S_RUN: begin
        REQ_READY = g_q ? 2'b10 : 2'b01;
        if (g_valid) ACC_A = g_data;
      end
      S_DONE: begin
        RES_VALID = 1'b1;
        RES_ID    = g_q;
        RES_SUM   = ACC_SOUT;
        RES_OVF   = ovf_q;
        RES_CNT   = cnt_q;
        RES_ERR   = err_q;
      end
      default: ACC_RST = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_accum_sched.sv
// tb_accum_sched: scoreboard bench for accum_sched with a behavioural accumulator.
// Expected results are queued as jobs are driven and popped when RES_VALID shows up.
module tb_accum_sched;

  localparam int W = 4;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic             id;
    logic [W-1:0]     sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } res_t;

  logic             PHI = 1'b0;
  logic             RST_N;
  logic [1:0]       REQ_VALID;
  logic [2*W-1:0]   REQ_DATA;
  logic [1:0]       REQ_LAST;
  logic [1:0]       REQ_READY;
  logic [W-1:0]     ACC_A;
  logic             ACC_CIN;
  logic             ACC_RST;
  logic [W-1:0]     ACC_SOUT;
  logic             ACC_COUT;
  logic             RES_VALID;
  logic             RES_READY;
  logic             RES_ID;
  logic [W-1:0]     RES_SUM;
  logic             RES_OVF;
  logic [CNT_W-1:0] RES_CNT;
  logic             RES_ERR;

  int n_cmp = 0;
  int n_bad = 0;

  res_t       exp_q[$];
  logic [3:0] bq[$];
  res_t       obs;

  always #5 PHI = ~PHI;

  accum_sched dut (
    .PHI       (PHI),
    .RST_N     (RST_N),
    .REQ_VALID (REQ_VALID),
    .REQ_DATA  (REQ_DATA),
    .REQ_LAST  (REQ_LAST),
    .REQ_READY (REQ_READY),
    .ACC_A     (ACC_A),
    .ACC_CIN   (ACC_CIN),
    .ACC_RST   (ACC_RST),
    .ACC_SOUT  (ACC_SOUT),
    .ACC_COUT  (ACC_COUT),
    .RES_VALID (RES_VALID),
    .RES_READY (RES_READY),
    .RES_ID    (RES_ID),
    .RES_SUM   (RES_SUM),
    .RES_OVF   (RES_OVF),
    .RES_CNT   (RES_CNT),
    .RES_ERR   (RES_ERR)
  );

  // External accumulator: registered sum, sync clear, comb carry.
  logic [W-1:0] acc_q = '0;
  logic [W:0]   acc_nx;
  assign acc_nx   = {1'b0, acc_q} + {1'b0, ACC_A} + {{W{1'b0}}, ACC_CIN};
  assign ACC_SOUT = acc_q;
  assign ACC_COUT = acc_nx[W];
  always @(posedge PHI) begin
    if (ACC_RST) acc_q <= '0;
    else         acc_q <= acc_nx[W-1:0];
  end

  assign obs = {RES_ID, RES_SUM, RES_OVF, RES_CNT, RES_ERR};

  function automatic res_t model(input logic id, input logic err);
    res_t r;
    logic [4:0] t;
    r = '0;
    r.id = id;
    r.err = err;
    foreach (bq[i]) begin
      t = {1'b0, r.sum} + {1'b0, bq[i]};
      r.ovf = r.ovf | t[4];
      r.sum = t[3:0];
      if (r.cnt != 4'hf) r.cnt = r.cnt + 1'b1;
    end
    return r;
  endfunction

  task automatic step;
    @(posedge PHI);
    #1;
  endtask

  task automatic send_beat(input int r, input logic [3:0] d,
                           input logic last);
    int n;
    REQ_VALID[r] = 1'b1;
    REQ_DATA[r*W +: W] = d;
    REQ_LAST[r] = last;
    n = 0;
    while (!REQ_READY[r] && n < 20) begin
      step;
      n++;
    end
    if (!REQ_READY[r]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL beat_ready_timeout req=%0d ready=%b required bit set",
               r, REQ_READY);
    end
    step;
  endtask

  task automatic run_job(input int r, input logic do_last);
    exp_q.push_back(model(r[0], !do_last));
    foreach (bq[i])
      send_beat(r, bq[i], do_last && (i == bq.size() - 1));
    REQ_VALID[r] = 1'b0;
    REQ_LAST[r] = 1'b0;
  endtask

  task automatic wait_res(output bit got);
    int n;
    n = 0;
    while (!RES_VALID && n < 40) begin
      step;
      n++;
    end
    got = RES_VALID;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL res_valid_timeout got=0 required=1");
    end
  endtask

  task automatic test_reset;
    RST_N = 1'b0;
    REQ_VALID = '0;
    REQ_DATA = '0;
    REQ_LAST = '0;
    RES_READY = 1'b1;
    repeat (3) step;
    n_cmp++;
    if ({REQ_READY, RES_VALID, ACC_RST, ACC_A, ACC_CIN} !==
        {2'b00, 1'b0, 1'b1, 4'h0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_ctrl got=%b/%b/%b/%h/%b required=00/0/1/0/0",
               REQ_READY, RES_VALID, ACC_RST, ACC_A, ACC_CIN);
    end
    n_cmp++;
    if (obs !== '0) begin
      n_bad++;
      $display("FAIL reset_res got=%h required=0", obs);
    end
    RST_N = 1'b1;
    step;
  endtask

  task automatic test_basic;
    bit got;
    res_t e;
    bq = '{4'd3, 4'd5, 4'd7};
    run_job(0, 1'b1);
    wait_res(got);
    if (got) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL basic_res got=%h required=%h", obs, e);
      end
    end
    step;
    n_cmp++;
    if (RES_VALID !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_one_cycle got=%b required=0", RES_VALID);
    end
  endtask

  task automatic test_overflow;
    bit got;
    res_t e;
    bq = '{4'd9, 4'd8};
    run_job(1, 1'b1);
    wait_res(got);
    if (got) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL ovf_res got=%h required=%h", obs, e);
      end
    end
    step;
  endtask

  task automatic contest(input logic [3:0] d0, input logic [3:0] d1,
                         input int first);
    logic [1:0] acc;
    int got_n;
    int t_first;
    res_t e;
    if (first == 0) begin
      bq = '{d0}; exp_q.push_back(model(1'b0, 1'b0));
      bq = '{d1}; exp_q.push_back(model(1'b1, 1'b0));
    end else begin
      bq = '{d1}; exp_q.push_back(model(1'b1, 1'b0));
      bq = '{d0}; exp_q.push_back(model(1'b0, 1'b0));
    end
    REQ_DATA = {d1, d0};
    REQ_LAST = 2'b11;
    REQ_VALID = 2'b11;
    got_n = 0;
    t_first = 0;
    for (int c = 0; c < 30 && got_n < 2; c++) begin
      acc = REQ_VALID & REQ_READY;
      step;
      REQ_VALID = REQ_VALID & ~acc;
      if (RES_VALID) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (obs !== e) begin
          n_bad++;
          $display("FAIL contest_res%0d got=%h required=%h",
                   got_n, obs, e);
        end
        if (got_n == 0) begin
          t_first = c;
        end else begin
          n_cmp++;
          if (c - t_first != 3) begin
            n_bad++;
            $display("FAIL contest_gap got=%0d required=3",
                     c - t_first);
          end
        end
        got_n++;
      end
    end
    n_cmp++;
    if (got_n != 2) begin
      n_bad++;
      $display("FAIL contest_count got=%0d required=2", got_n);
    end
    REQ_VALID = '0;
    REQ_LAST = '0;
    step;
  endtask

  task automatic test_back_to_back;
    bit got;
    res_t e;
    RST_N = 1'b0;
    step;
    RST_N = 1'b1;
    contest(4'd2, 4'd4, 0);
    bq = '{4'd3};
    run_job(0, 1'b1);
    wait_res(got);
    if (got) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL b2b_solo got=%h required=%h", obs, e);
      end
    end
    step;
    contest(4'd5, 4'd6, 1);
  endtask

  task automatic test_timeout;
    int n;
    res_t e;
    bq = '{4'd2};
    run_job(0, 1'b0);
    n = 0;
    while (!RES_VALID && n < 40) begin
      step;
      n++;
    end
    n_cmp++;
    if (n != 15) begin
      n_bad++;
      $display("FAIL timeout_cycles got=%0d required=15", n);
    end
    if (RES_VALID) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL timeout_res got=%h required=%h", obs, e);
      end
    end
    step;
  endtask

  task automatic test_reset_mid;
    bit got;
    bit seen;
    res_t e;
    send_beat(0, 4'd6, 1'b0);
    send_beat(0, 4'd6, 1'b0);
    REQ_VALID = '0;
    RST_N = 1'b0;
    step;
    RST_N = 1'b1;
    n_cmp++;
    if ({REQ_READY, RES_VALID, ACC_RST} !== {2'b00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_idle got=%b/%b/%b required=00/0/1",
               REQ_READY, RES_VALID, ACC_RST);
    end
    seen = 1'b0;
    repeat (5) begin
      step;
      if (RES_VALID) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL midrst_noresult got=1 required=0");
    end
    bq = '{4'd1};
    run_job(0, 1'b1);
    wait_res(got);
    if (got) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL midrst_res got=%h required=%h", obs, e);
      end
    end
    step;
  endtask

  task automatic test_stall;
    bit got;
    res_t e;
    res_t snap;
    RES_READY = 1'b0;
    bq = '{4'd5, 4'd5};
    run_job(1, 1'b1);
    wait_res(got);
    if (got) begin
      snap = obs;
      e = exp_q.pop_front();
      n_cmp++;
      if (snap !== e) begin
        n_bad++;
        $display("FAIL stall_res got=%h required=%h", snap, e);
      end
      REQ_VALID = 2'b11;
      REQ_DATA = 8'h33;
      for (int i = 0; i < 4; i++) begin
        step;
        n_cmp++;
        if ({RES_VALID, obs, REQ_READY} !== {1'b1, e, 2'b00}) begin
          n_bad++;
          $display("FAIL stall_hold%0d got=%b/%h/%b required=1/%h/00",
                   i, RES_VALID, obs, REQ_READY, e);
        end
      end
      REQ_VALID = '0;
      RES_READY = 1'b1;
      step;
      n_cmp++;
      if (RES_VALID !== 1'b0) begin
        n_bad++;
        $display("FAIL stall_release got=%b required=0", RES_VALID);
      end
    end
    RES_READY = 1'b1;
    step;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_overflow;
    test_back_to_back;
    test_timeout;
    test_reset_mid;
    test_stall;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
